// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, channel ids and default address width for the SDRAM arbiter
package sdram_arb_pkg;
    localparam int ADDR_W_DEF = 25;
    typedef enum logic [1:0] {ST_IDLE, ST_REF, ST_WR, ST_RD} state_e;
    typedef enum logic {CH_WR, CH_RD} ch_e;
endpackage

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: auto-refresh interval counter with pending flag and sticky overrun
module sdram_ref_timer #(
    parameter int REF_CYCLES = 780,
    parameter int REF_CNT_W  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic pend,
    output logic overrun
);
    logic [REF_CNT_W-1:0] cnt_q, cnt_d;
    logic pend_q, pend_d, overrun_q, overrun_d, expire;
    always_comb begin
        expire    = en && (cnt_q == REF_CNT_W'(REF_CYCLES - 1));
        cnt_d     = !en ? cnt_q : expire ? '0 : cnt_q + REF_CNT_W'(1);
        pend_d    = expire | (pend_q & ~clr);
        // an expiry coinciding with the clearing ack just re-arms the request
        overrun_d = overrun_q | (expire & pend_q & ~clr);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end
    assign pend    = pend_q;
    assign overrun = overrun_q;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: schedules refresh (top priority) and round-robin write/read bursts onto the sdram_intf command port
module sdram_arbiter import sdram_arb_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int REF_CYCLES = 780,
    parameter int REF_CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              wr_ch_req,
    input  logic [ADDR_W-1:0] wr_ch_addr,
    output logic              wr_ch_gnt,
    output logic              wr_ch_done,
    input  logic              rd_ch_req,
    input  logic [ADDR_W-1:0] rd_ch_addr,
    output logic              rd_ch_gnt,
    output logic              rd_ch_done,
    output logic              mem_wr_req,
    output logic              mem_rd_req,
    output logic              mem_ref_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              ref_overrun
);
    state_e state_q, state_d;
    ch_e last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic ref_pend, pick_wr, pick_rd;
    sdram_ref_timer #(.REF_CYCLES(REF_CYCLES), .REF_CNT_W(REF_CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (init_done),
        .clr    (mem_ack && state_q == ST_REF),
        .pend   (ref_pend),
        .overrun(ref_overrun)
    );
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        pick_wr = wr_ch_req && (!rd_ch_req || last_q == CH_RD);
        pick_rd = rd_ch_req && !pick_wr;
        if (state_q == ST_IDLE) begin
            if (init_done && ref_pend) begin
                state_d = ST_REF;
            end else if (init_done && pick_wr) begin
                state_d = ST_WR;
                last_d  = CH_WR;
                addr_d  = wr_ch_addr;
            end else if (init_done && pick_rd) begin
                state_d = ST_RD;
                last_d  = CH_RD;
                addr_d  = rd_ch_addr;
            end
        end else if (mem_ack) begin
            state_d = ST_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= CH_RD;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end
    assign mem_wr_req  = state_q == ST_WR;
    assign mem_rd_req  = state_q == ST_RD;
    assign mem_ref_req = state_q == ST_REF;
    assign wr_ch_gnt   = mem_wr_req;
    assign rd_ch_gnt   = mem_rd_req;
    assign wr_ch_done  = mem_ack && mem_wr_req;
    assign rd_ch_done  = mem_ack && mem_rd_req;
    assign mem_addr    = addr_q;
    a_one_op: assert property (@(posedge clk) disable iff (rst) $onehot0({mem_wr_req, mem_rd_req, mem_ref_req}));
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench with an sdram_intf model that acks 8 clk after a request
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;
    localparam int AW = 25;
    typedef struct packed {logic [1:0] op; logic [AW-1:0] addr;} exp_t;
    logic clk = 0, rst = 1, init_done = 0, wr_ch_req = 0, rd_ch_req = 0, mem_ack = 0, hold_ack = 0;
    logic [AW-1:0] wr_ch_addr = '0, rd_ch_addr = '0, mem_addr;
    logic wr_ch_gnt, wr_ch_done, rd_ch_gnt, rd_ch_done, mem_wr_req, mem_rd_req, mem_ref_req, ref_overrun;
    int total = 0, bad = 0, ack_cnt = 0, refs = 0;
    logic [1:0] op_now = 0, op_prev = 0;
    exp_t sb[$];
    exp_t e;
    always #5 clk = ~clk;
    sdram_arbiter #(.ADDR_W(AW), .REF_CYCLES(50), .REF_CNT_W(10)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .wr_ch_req(wr_ch_req), .wr_ch_addr(wr_ch_addr), .wr_ch_gnt(wr_ch_gnt), .wr_ch_done(wr_ch_done),
        .rd_ch_req(rd_ch_req), .rd_ch_addr(rd_ch_addr), .rd_ch_gnt(rd_ch_gnt), .rd_ch_done(rd_ch_done),
        .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req), .mem_ref_req(mem_ref_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .ref_overrun(ref_overrun)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic wait_done(input bit rd, input string tag);
        int n = 0;
        while (!(rd ? rd_ch_done : wr_ch_done) && n < 100) begin
            tick();
            n++;
        end
        chk(tag, rd ? rd_ch_done : wr_ch_done, 1);
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, "_reqs"}, {mem_wr_req, mem_rd_req, mem_ref_req}, 0);
        chk({tag, "_gnts"}, {wr_ch_gnt, rd_ch_gnt, wr_ch_done, rd_ch_done}, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_state"}, dut.state_q, ST_IDLE);
        chk({tag, "_last"}, dut.last_q, CH_RD);
        chk({tag, "_ovr"}, ref_overrun, 0);
        chk({tag, "_pend"}, dut.u_timer.pend_q, 0);
    endtask
    always begin
        @(posedge clk);
        #1;
        if (mem_ack) begin
            mem_ack = 0;
            ack_cnt = 0;
        end else if (hold_ack && mem_ref_req) begin
            ack_cnt = ack_cnt;
        end else if (mem_wr_req || mem_rd_req || mem_ref_req) begin
            ack_cnt++;
            if (ack_cnt >= 8) mem_ack = 1;
        end else begin
            ack_cnt = 0;
        end
    end
    always begin
        @(negedge clk);
        chk("onehot", 32'($onehot0({mem_wr_req, mem_rd_req, mem_ref_req})), 1);
        op_now = mem_wr_req ? 2'd1 : mem_rd_req ? 2'd2 : mem_ref_req ? 2'd3 : 2'd0;
        if (op_now != 0 && op_now != op_prev) begin
            if (op_now == 3) begin
                refs++;
            end else if (sb.size() == 0) begin
                chk("unexp_grant", op_now, 0);
            end else begin
                e = sb.pop_front();
                chk("grant_op", op_now, e.op);
                chk("grant_addr", mem_addr, e.addr);
            end
        end
        op_prev = op_now;
    end
    initial begin
        int busy, n, wd, rdn;
        tick(3);
        chk_quiet("reset");
        chk("reset_cnt", dut.u_timer.cnt_q, 0);
        rst = 0;
        wr_ch_req = 1;
        wr_ch_addr = 25'h0_1234;
        busy = 0;
        repeat (100) begin
            tick();
            if (wr_ch_gnt || mem_wr_req || mem_rd_req || mem_ref_req) busy++;
        end
        chk("no_init_busy", busy, 0);
        chk("cnt_held", dut.u_timer.cnt_q, 0);
        sb.push_back('{2'd1, 25'h0_1234});
        init_done = 1;
        tick();
        chk("wr_latency", mem_wr_req, 1);
        chk("wr_gnt", wr_ch_gnt, 1);
        chk("wr_addr", mem_addr, 25'h0_1234);
        wait_done(0, "wr_done");
        wr_ch_req = 0;
        tick();
        chk("idle_after_wr", dut.state_q, ST_IDLE);
        chk("done_pulse", wr_ch_done, 0);
        busy = 0;
        repeat (5) begin
            tick();
            if (mem_wr_req) busy++;
        end
        chk("no_regrant", busy, 0);
        rd_ch_addr = 25'h1_0000;
        sb.push_back('{2'd2, 25'h1_0000});
        rd_ch_req = 1;
        wait_done(1, "rd_done");
        rd_ch_req = 0;
        tick(2);
        wr_ch_addr = 25'h0_1000;
        rd_ch_addr = 25'h1_1000;
        sb.push_back('{2'd1, 25'h0_1000});
        sb.push_back('{2'd2, 25'h1_1000});
        sb.push_back('{2'd1, 25'h0_1100});
        sb.push_back('{2'd2, 25'h1_1100});
        wr_ch_req = 1;
        rd_ch_req = 1;
        n = 0; wd = 0; rdn = 0;
        while ((wd < 2 || rdn < 2) && n < 300) begin
            tick();
            n++;
            if (wr_ch_done) begin
                wd++;
                wr_ch_addr = wr_ch_addr + 25'h100;
                if (wd == 2) wr_ch_req = 0;
            end
            if (rd_ch_done) begin
                rdn++;
                rd_ch_addr = rd_ch_addr + 25'h100;
                if (rdn == 2) rd_ch_req = 0;
            end
        end
        chk("alt_wr_count", wd, 2);
        chk("alt_rd_count", rdn, 2);
        tick(2);
        n = 0;
        while (!(dut.u_timer.cnt_q == 45 && dut.state_q == ST_IDLE && !dut.u_timer.pend_q) && n < 200) begin
            tick();
            n++;
        end
        chk("t4_sync", n < 200, 1);
        wr_ch_addr = 25'h0_4444;
        rd_ch_addr = 25'h1_4444;
        sb.push_back('{2'd1, 25'h0_4444});
        sb.push_back('{2'd2, 25'h1_4444});
        wr_ch_req = 1;
        rd_ch_req = 1;
        wait_done(0, "t4_wr_done");
        wr_ch_req = 0;
        chk("t4_pend_mid", dut.u_timer.pend_q, 1);
        tick(2);
        chk("t4_ref_first", mem_ref_req, 1);
        chk("t4_rd_waits", rd_ch_gnt, 0);
        wait_done(1, "t4_rd_done");
        rd_ch_req = 0;
        chk("t4_pend_clr", dut.u_timer.pend_q, 0);
        chk("t4_no_ovr", ref_overrun, 0);
        hold_ack = 1;
        n = 0;
        while (!mem_ref_req && n < 100) begin
            tick();
            n++;
        end
        chk("t5_ref", mem_ref_req, 1);
        tick(60);
        chk("t5_ovr", ref_overrun, 1);
        hold_ack = 0;
        tick(20);
        chk("t5_sticky", ref_overrun, 1);
        n = 0;
        while (!(dut.state_q == ST_IDLE && !dut.u_timer.pend_q && dut.u_timer.cnt_q < 20) && n < 200) begin
            tick();
            n++;
        end
        chk("t6_sync", n < 200, 1);
        rd_ch_addr = 25'h1_6666;
        sb.push_back('{2'd2, 25'h1_6666});
        rd_ch_req = 1;
        n = 0;
        while (!rd_ch_gnt && n < 30) begin
            tick();
            n++;
        end
        chk("t6_rd_gnt", rd_ch_gnt, 1);
        tick(3);
        rst = 1;
        rd_ch_req = 0;
        tick();
        chk_quiet("t6_rst");
        rst = 0;
        wr_ch_addr = 25'h0_7777;
        rd_ch_addr = 25'h1_7777;
        sb.push_back('{2'd1, 25'h0_7777});
        wr_ch_req = 1;
        rd_ch_req = 1;
        wait_done(0, "t6_wr_done");
        wr_ch_req = 0;
        rd_ch_req = 0;
        tick(5);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
